pll_lock_sequencer: RTL and testbench

Power-up and relock controller for a single fabric PLL. Runs on the PLL reference clock and drives PLL enable and runtime divider settings. It samples the asynchronous LOCK output and qualifies it for stability. Only after a qualified lock does it open downstream clock gates and release a system reset. It also accepts new divider configurations over a valid/ready handshake, detects loss of lock, and re-sequences automatically.

---
 rtl/pll_lock_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL power-up/relock sequencer with lock qualification and divider config handshake
// Optional timeout auto-retry enabled by defining PLL_SEQ_AUTO_RETRY_EN.
module pll_lock_sequencer #(
`ifdef PLL_SEQ_AUTO_RETRY_EN
  parameter int unsigned MAX_RETRY    = 3,
`endif
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned OFF_CYCLES    = 16,
  parameter logic [6:0]  DEF_MULT      = 7'd64,
  parameter logic [1:0]  DEF_DIV       = 2'd2,
  parameter logic [5:0]  DEF_POST_DIV  = 6'd32,
  parameter logic        DEF_DIV2      = 1'b0
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       start,
  input  logic       pll_lock,
  input  logic       cfg_valid,
  input  logic [6:0] cfg_mult,
  input  logic [1:0] cfg_div,
  input  logic [5:0] cfg_post_div,
  input  logic       cfg_div2,
  output logic       cfg_ready,
  output logic       cfg_err,
  output logic       pll_en,
  output logic [6:0] pll_mult,
  output logic [1:0] pll_div,
  output logic [5:0] pll_post_div,
  output logic       pll_div2,
  output logic       clk_gate_en,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       fault,
  output logic [7:0] lol_count,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PWRDN     = 3'd1;
  localparam logic [2:0] S_WAIT_LOCK = 3'd2;
  localparam logic [2:0] S_SETTLE    = 3'd3;
  localparam logic [2:0] S_LOCKED    = 3'd4;
  localparam logic [2:0] S_FAULT     = 3'd5;

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + STABLE_CYCLES + OFF_CYCLES + 1);

  logic             lock_meta;
  logic             lock_s;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             counting;
  logic [1:0]       rst_dly;
  logic             cfg_ok;
  logic             cfg_fire;
  logic             cfg_accept;
  logic             lol_event;

`ifdef PLL_SEQ_AUTO_RETRY_EN
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0] retry_cnt;
  logic [RETRY_W-1:0] retry_nxt;
`endif

  assign cfg_ready   = (state == S_IDLE) || (state == S_LOCKED) || (state == S_FAULT);
  assign cfg_ok      = (cfg_mult >= 7'd16) && (cfg_div != 2'd0) && (cfg_post_div != 6'd0);
  assign cfg_fire    = cfg_valid && cfg_ready;
  assign cfg_accept  = cfg_fire && cfg_ok;
  assign lol_event   = (state == S_LOCKED) && !lock_s;
  assign counting    = (state == S_PWRDN) || (state == S_WAIT_LOCK) || (state == S_SETTLE);

  assign pll_en      = (state == S_WAIT_LOCK) || (state == S_SETTLE);
  assign clk_gate_en = (state == S_LOCKED);
  assign locked      = (state == S_LOCKED);
  assign fault       = (state == S_FAULT);
  assign sys_rst_n   = rst_dly[1];

  always_comb begin
    state_nxt = state;
`ifdef PLL_SEQ_AUTO_RETRY_EN
    retry_nxt = retry_cnt;
`endif
    case (state)
      S_IDLE: begin
`ifdef PLL_SEQ_AUTO_RETRY_EN
        retry_nxt = '0;
`endif
        if (start) state_nxt = S_PWRDN;
      end
      S_PWRDN: begin
        if (cnt == CNT_W'(OFF_CYCLES - 1)) state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = S_SETTLE;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
`ifdef PLL_SEQ_AUTO_RETRY_EN
          if (32'(retry_cnt) < MAX_RETRY) begin
            state_nxt = S_PWRDN;
            retry_nxt = retry_cnt + 1'b1;
          end else begin
            state_nxt = S_FAULT;
          end
`else
          state_nxt = S_FAULT;
`endif
        end
      end
      S_SETTLE: begin
        // Any drop in the synchronized lock restarts qualification from scratch.
        if (!lock_s) begin
          state_nxt = S_WAIT_LOCK;
        end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          state_nxt = S_LOCKED;
`ifdef PLL_SEQ_AUTO_RETRY_EN
          retry_nxt = '0;
`endif
        end
      end
      S_LOCKED: begin
        if (!lock_s || cfg_accept) state_nxt = S_PWRDN;
      end
      S_FAULT: begin
        if (cfg_accept) begin
          state_nxt = S_PWRDN;
`ifdef PLL_SEQ_AUTO_RETRY_EN
          retry_nxt = '0;
`endif
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!start) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta    <= 1'b0;
      lock_s       <= 1'b0;
      state        <= S_IDLE;
      cnt          <= '0;
      rst_dly      <= 2'b00;
      cfg_err      <= 1'b0;
      lol_count    <= 8'd0;
      pll_mult     <= DEF_MULT;
      pll_div      <= DEF_DIV;
      pll_post_div <= DEF_POST_DIV;
      pll_div2     <= DEF_DIV2;
`ifdef PLL_SEQ_AUTO_RETRY_EN
      retry_cnt    <= '0;
`endif
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
      state     <= state_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (counting) begin
        cnt <= cnt + 1'b1;
      end
      // sys_rst_n follows gate opening by two cycles and drops on the same edge as the gates.
      if ((state == S_LOCKED) && (state_nxt == S_LOCKED)) begin
        rst_dly <= {rst_dly[0], 1'b1};
      end else begin
        rst_dly <= 2'b00;
      end
      cfg_err <= cfg_fire && !cfg_ok;
      if (cfg_accept) begin
        pll_mult     <= cfg_mult;
        pll_div      <= cfg_div;
        pll_post_div <= cfg_post_div;
        pll_div2     <= cfg_div2;
      end
      if (lol_event && (lol_count != 8'hFF)) lol_count <= lol_count + 8'd1;
`ifdef PLL_SEQ_AUTO_RETRY_EN
      retry_cnt <= retry_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - directed self-checking bench for pll_lock_sequencer
module tb_pll_lock_sequencer;

  logic       clk_in;
  logic       reset_n;
  logic       start;
  logic       pll_lock;
  logic       cfg_valid;
  logic [6:0] cfg_mult;
  logic [1:0] cfg_div;
  logic [5:0] cfg_post_div;
  logic       cfg_div2;
  logic       cfg_ready;
  logic       cfg_err;
  logic       pll_en;
  logic [6:0] pll_mult;
  logic [1:0] pll_div;
  logic [5:0] pll_post_div;
  logic       pll_div2;
  logic       clk_gate_en;
  logic       sys_rst_n;
  logic       locked;
  logic       fault;
  logic [7:0] lol_count;
  logic [2:0] state;

  int pass_cnt;
  int check_cnt;

  pll_lock_sequencer dut (
    .clk_in(clk_in), .reset_n(reset_n), .start(start), .pll_lock(pll_lock),
    .cfg_valid(cfg_valid), .cfg_mult(cfg_mult), .cfg_div(cfg_div),
    .cfg_post_div(cfg_post_div), .cfg_div2(cfg_div2), .cfg_ready(cfg_ready),
    .cfg_err(cfg_err), .pll_en(pll_en), .pll_mult(pll_mult), .pll_div(pll_div),
    .pll_post_div(pll_post_div), .pll_div2(pll_div2), .clk_gate_en(clk_gate_en),
    .sys_rst_n(sys_rst_n), .locked(locked), .fault(fault), .lol_count(lol_count),
    .state(state)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; pll_lock = 1'b0; cfg_valid = 1'b0;
    cfg_mult = 7'd0; cfg_div = 2'd0; cfg_post_div = 6'd0; cfg_div2 = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  // Reaches LOCKED with sys_rst_n released; lock edge right after pll_en rises.
  task automatic bring_up();
    do_reset();
    start = 1'b1;
    tick(17);
    pll_lock = 1'b1;
    tick(259);
    tick(2);
  endtask

  task automatic test_reset();
    do_reset();
    check_cnt++; if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else pass_cnt++;
    check_cnt++; if ({pll_en, clk_gate_en, locked, fault, cfg_err, sys_rst_n} !== 6'b0)
      $display("FAIL reset_flags: got %b want 000000", {pll_en, clk_gate_en, locked, fault, cfg_err, sys_rst_n}); else pass_cnt++;
    check_cnt++; if (lol_count !== 8'd0) $display("FAIL reset_lol: got %0d want 0", lol_count); else pass_cnt++;
    check_cnt++; if ({pll_mult, pll_div, pll_post_div, pll_div2} !== {7'd64, 2'd2, 6'd32, 1'b0})
      $display("FAIL reset_div: got %0d/%0d/%0d/%0d want 64/2/32/0", pll_mult, pll_div, pll_post_div, pll_div2); else pass_cnt++;
    check_cnt++; if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); else pass_cnt++;
  endtask

  task automatic test_default_bringup();
    do_reset();
    start = 1'b1;
    tick(16);
    check_cnt++; if (pll_en !== 1'b0) $display("FAIL bring_pll_en_c16: got %b want 0", pll_en); else pass_cnt++;
    tick(1);
    check_cnt++; if (pll_en !== 1'b1) $display("FAIL bring_pll_en_c17: got %b want 1", pll_en); else pass_cnt++;
    check_cnt++; if (cfg_ready !== 1'b0) $display("FAIL bring_cfg_ready_wait: got %b want 0", cfg_ready); else pass_cnt++;
    tick(100);
    pll_lock = 1'b1;
    tick(258);
    check_cnt++; if (clk_gate_en !== 1'b0) $display("FAIL bring_gate_early: got %b want 0", clk_gate_en); else pass_cnt++;
    tick(1);
    check_cnt++; if (clk_gate_en !== 1'b1) $display("FAIL bring_gate_on: got %b want 1", clk_gate_en); else pass_cnt++;
    check_cnt++; if (sys_rst_n !== 1'b0) $display("FAIL bring_rst_c0: got %b want 0", sys_rst_n); else pass_cnt++;
    tick(1);
    check_cnt++; if (sys_rst_n !== 1'b0) $display("FAIL bring_rst_c1: got %b want 0", sys_rst_n); else pass_cnt++;
    tick(1);
    check_cnt++; if (sys_rst_n !== 1'b1) $display("FAIL bring_rst_c2: got %b want 1", sys_rst_n); else pass_cnt++;
    check_cnt++; if ({locked, state} !== {1'b1, 3'd4}) $display("FAIL bring_locked: got %b/%0d want 1/4", locked, state); else pass_cnt++;
    check_cnt++; if ({pll_mult, pll_div, pll_post_div} !== {7'd64, 2'd2, 6'd32})
      $display("FAIL bring_div: got %0d/%0d/%0d want 64/2/32", pll_mult, pll_div, pll_post_div); else pass_cnt++;
  endtask

  task automatic test_lock_glitch();
    logic       gate_seen;
    logic [2:0] st_settle;
    gate_seen = 1'b0;
    st_settle = 3'd7;
    do_reset();
    start = 1'b1;
    tick(17);
    pll_lock = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick(1);
      gate_seen = gate_seen | clk_gate_en;
      if (i == 3) st_settle = state;
    end
    pll_lock = 1'b0;
    tick(2);
    gate_seen = gate_seen | clk_gate_en;
    check_cnt++; if (st_settle !== 3'd3) $display("FAIL glitch_enter_settle: got %0d want 3", st_settle); else pass_cnt++;
    check_cnt++; if (state !== 3'd3) $display("FAIL glitch_still_settle: got %0d want 3", state); else pass_cnt++;
    tick(1);
    check_cnt++; if (state !== 3'd2) $display("FAIL glitch_back_wait: got %0d want 2", state); else pass_cnt++;
    check_cnt++; if (gate_seen !== 1'b0) $display("FAIL glitch_gate: got %b want 0", gate_seen); else pass_cnt++;
    check_cnt++; if (lol_count !== 8'd0) $display("FAIL glitch_lol: got %0d want 0", lol_count); else pass_cnt++;
  endtask

  task automatic test_loss_of_lock();
    bring_up();
    pll_lock = 1'b0;
    tick(2);
    check_cnt++; if (clk_gate_en !== 1'b1) $display("FAIL lol_gate_c2: got %b want 1", clk_gate_en); else pass_cnt++;
    tick(1);
    check_cnt++; if ({clk_gate_en, sys_rst_n} !== 2'b00) $display("FAIL lol_outputs_c3: got %b want 00", {clk_gate_en, sys_rst_n}); else pass_cnt++;
    check_cnt++; if (lol_count !== 8'd1) $display("FAIL lol_count: got %0d want 1", lol_count); else pass_cnt++;
    check_cnt++; if (state !== 3'd1) $display("FAIL lol_state: got %0d want 1", state); else pass_cnt++;
    tick(15);
    check_cnt++; if (pll_en !== 1'b0) $display("FAIL lol_off_c15: got %b want 0", pll_en); else pass_cnt++;
    tick(1);
    check_cnt++; if (pll_en !== 1'b1) $display("FAIL lol_off_c16: got %b want 1", pll_en); else pass_cnt++;
    pll_lock = 1'b1;
    tick(259);
    check_cnt++; if ({locked, lol_count} !== {1'b1, 8'd1}) $display("FAIL lol_relock: got %b/%0d want 1/1", locked, lol_count); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int   rises;
    int   n_cyc;
    int   want_rises;
    logic early;
    logic prev;
`ifdef PLL_SEQ_AUTO_RETRY_EN
    n_cyc = 16449;
    want_rises = 4;
`else
    n_cyc = 4113;
    want_rises = 1;
`endif
    rises = 0;
    early = 1'b0;
    do_reset();
    prev = pll_en;
    start = 1'b1;
    for (int i = 1; i <= n_cyc; i++) begin
      tick(1);
      if (pll_en && !prev) rises++;
      prev = pll_en;
      if ((i < n_cyc) && fault) early = 1'b1;
    end
    check_cnt++; if (early !== 1'b0) $display("FAIL timeout_early_fault: got %b want 0", early); else pass_cnt++;
    check_cnt++; if ({fault, state, pll_en} !== {1'b1, 3'd5, 1'b0})
      $display("FAIL timeout_fault: got %b/%0d/%b want 1/5/0", fault, state, pll_en); else pass_cnt++;
    check_cnt++; if (rises != want_rises) $display("FAIL timeout_attempts: got %0d want %0d", rises, want_rises); else pass_cnt++;
    start = 1'b0;
    tick(1);
    check_cnt++; if ({fault, state} !== {1'b0, 3'd0}) $display("FAIL fault_exit: got %b/%0d want 0/0", fault, state); else pass_cnt++;
  endtask

  task automatic test_cfg_locked();
    bring_up();
    cfg_mult = 7'd80; cfg_div = 2'd1; cfg_post_div = 6'd16; cfg_div2 = 1'b1;
    cfg_valid = 1'b1;
    check_cnt++; if (cfg_ready !== 1'b1) $display("FAIL cfg_ready_locked: got %b want 1", cfg_ready); else pass_cnt++;
    tick(1);
    cfg_valid = 1'b0;
    check_cnt++; if ({state, clk_gate_en, cfg_err} !== {3'd1, 1'b0, 1'b0})
      $display("FAIL cfg_accept_state: got %0d/%b/%b want 1/0/0", state, clk_gate_en, cfg_err); else pass_cnt++;
    check_cnt++; if ({pll_mult, pll_div, pll_post_div, pll_div2} !== {7'd80, 2'd1, 6'd16, 1'b1})
      $display("FAIL cfg_latch: got %0d/%0d/%0d/%0d want 80/1/16/1", pll_mult, pll_div, pll_post_div, pll_div2); else pass_cnt++;
    tick(272);
    check_cnt++; if (locked !== 1'b0) $display("FAIL cfg_relock_early: got %b want 0", locked); else pass_cnt++;
    tick(1);
    check_cnt++; if ({locked, lol_count, pll_mult} !== {1'b1, 8'd0, 7'd80})
      $display("FAIL cfg_relock: got %b/%0d/%0d want 1/0/80", locked, lol_count, pll_mult); else pass_cnt++;
  endtask

  task automatic test_cfg_reject();
    cfg_mult = 7'd8; cfg_div = 2'd3; cfg_post_div = 6'd4; cfg_div2 = 1'b0;
    cfg_valid = 1'b1;
    tick(1);
    cfg_valid = 1'b0;
    check_cnt++; if (cfg_err !== 1'b1) $display("FAIL rej_err_pulse: got %b want 1", cfg_err); else pass_cnt++;
    check_cnt++; if ({state, pll_mult, pll_div, pll_post_div} !== {3'd4, 7'd80, 2'd1, 6'd16})
      $display("FAIL rej_unchanged: got %0d/%0d/%0d/%0d want 4/80/1/16", state, pll_mult, pll_div, pll_post_div); else pass_cnt++;
    tick(1);
    check_cnt++; if (cfg_err !== 1'b0) $display("FAIL rej_err_clear: got %b want 0", cfg_err); else pass_cnt++;
  endtask

  task automatic test_reset_mid_settle();
    do_reset();
    cfg_mult = 7'd100; cfg_div = 2'd3; cfg_post_div = 6'd5; cfg_div2 = 1'b1;
    cfg_valid = 1'b1;
    tick(1);
    cfg_valid = 1'b0;
    check_cnt++; if (pll_mult !== 7'd100) $display("FAIL idle_cfg: got %0d want 100", pll_mult); else pass_cnt++;
    start = 1'b1;
    tick(17);
    pll_lock = 1'b1;
    tick(10);
    check_cnt++; if (state !== 3'd3) $display("FAIL rst_pre_settle: got %0d want 3", state); else pass_cnt++;
    reset_n = 1'b0;
    #1;
    check_cnt++; if ({state, pll_en, clk_gate_en, sys_rst_n, fault, locked} !== {3'd0, 5'b0})
      $display("FAIL rst_async_state: got %0d/%b%b%b%b%b want 0/00000", state, pll_en, clk_gate_en, sys_rst_n, fault, locked); else pass_cnt++;
    check_cnt++; if ({pll_mult, pll_div, pll_post_div, pll_div2} !== {7'd64, 2'd2, 6'd32, 1'b0})
      $display("FAIL rst_async_div: got %0d/%0d/%0d/%0d want 64/2/32/0", pll_mult, pll_div, pll_post_div, pll_div2); else pass_cnt++;
    tick(1);
    reset_n = 1'b1;
    start = 1'b0;
  endtask

  initial begin
    pass_cnt = 0;
    check_cnt = 0;
    reset_n = 1'b0;
    test_reset();
    test_default_bringup();
    test_lock_glitch();
    test_loss_of_lock();
    test_timeout();
    test_cfg_locked();
    test_cfg_reject();
    test_reset_mid_settle();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
